aes_entropy_responder: RTL and testbench
========================================

Name: aes_entropy_responder

Overview:
- Supplier end of the AES entropy request/acknowledge interface used by the masking PRNG reseed path.
- Accepts wide generated-bits blocks from the upstream CSRNG stream through valid/ready.
- Buffers one block, slices it into EntropyWidth words, least-significant word first, and serves one word per acknowledged request.
- Sits between the CSRNG genbits port and the AES masking PRNG.

Parameters:
- GenBitsWidth, 128, width of one upstream block; must be an integer multiple of EntropyWidth.
- EntropyWidth, 32, width of one served word.
- NumWords, GenBitsWidth/EntropyWidth (4), derived; words per block.
- CntWidth, 16, width of the served-word counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous flush of buffered entropy.
- genbits_valid_i  in  1  upstream block valid.
- genbits_ready_o  out  1  responder can accept a block.
- genbits_i  in  GenBitsWidth  upstream block.
- genbits_fips_i  in  1  upstream block FIPS-qualified.
- entropy_req_i  in  1  consumer requests a word; held high until served.
- entropy_ack_o  out  1  word served this cycle.
- entropy_o  out  EntropyWidth  served word; valid only while entropy_ack_o is 1.
- entropy_fips_o  out  1  FIPS flag of the served word's block.
- served_cnt_o  out  CntWidth  saturating count of words served since reset.

Behaviour:
- Reset values:
  - Buffer invalid, word index idx = 0, buffer cleared to 0, fips = 0.
  - entropy_ack_o = 0, entropy_o = 0, entropy_fips_o = 0, served_cnt_o = 0.
  - genbits_ready_o = 1 (combinational from the reset state).
- State machine, encoded by buffer valid bit buf_vld:
  - EMPTY (buf_vld = 0).
  - SERVING (buf_vld = 1).
- Acknowledge (combinational): entropy_ack_o = entropy_req_i & buf_vld & ~clr_i.
  - Zero-cycle latency once the buffer is full, so a consumer that drops its request on an internal condition never receives an extra word.
- Served data (combinational): entropy_o = buf[idx*EntropyWidth +: EntropyWidth] and entropy_fips_o = buf_fips, both gated to 0 when entropy_ack_o = 0.
- Consume: on each ack cycle, idx increments.
  - When idx == NumWords-1, idx wraps to 0 and buf_vld clears (SERVING -> EMPTY), unless a refill occurs in the same cycle.
- Ready: genbits_ready_o = ~clr_i & (~buf_vld | (entropy_ack_o & idx == NumWords-1)).
  - Permits a refill in the same cycle the last word is served.
- Load: when genbits_valid_i & genbits_ready_o:
  - buf <= genbits_i, buf_fips <= genbits_fips_i, idx <= 0, buf_vld <= 1.
  - Last-word consume plus load in the same cycle: go directly SERVING -> SERVING with the new block and idx = 0; no bubble on the next request.
- Each word is served exactly once; words are never repeated or reordered.
- clr_i: next cycle buf_vld = 0, idx = 0, buf = 0, buf_fips = 0.
  - During the clr_i cycle, no ack and no load (ready = 0).
  - clr_i has priority over every simultaneous event.
- served_cnt_o increments by 1 per ack, saturates at all-ones, is unaffected by clr_i, and is cleared only by reset.
- Request low: buffer holds indefinitely with no state change.
- Asynchronous reset mid-operation discards buffered words; the upstream block in flight is lost. The consumer must re-request.
- Handshake assumptions: upstream holds genbits_i stable while valid is high and ready is low. A consumer request may be asserted in any cycle.

Test Plan:
- Reset, then upstream offers 128'h44444444_33333333_22222222_11111111 with fips = 1; entropy_req_i held high -> acks on 4 consecutive cycles starting the cycle after load, entropy_o = 11111111, 22222222, 33333333, 44444444, fips = 1 each; then ack = 0; served_cnt_o = 4.
- Second block pending with valid high during the 4th ack -> ready = 1 in that cycle; next cycle ack continues with word0 of the new block (no gap); 8 contiguous acks total.
- Consumer asserts req for 1 cycle at a time with gaps of 3 cycles -> exactly one ack per req cycle, idx advances by 1 per ack; ack never asserted while req = 0.
- After 2 words served, pulse clr_i together with req = 1 -> ack = 0 in that cycle; next cycle buffer empty, ready = 1; a new block is served from word0.
- Buffer empty with req = 1 for 10 cycles -> ack stays 0, ready stays 1; block arrives -> ack on the following cycle.
- Deassert rst_ni mid-block (idx = 2) -> all outputs 0 and ready = 1 immediately; served_cnt_o = 0. Separately, force the counter to all-ones and serve one more word -> served_cnt_o remains all-ones.

Source files
------------

// File: rtl/aes_entropy_responder.sv
// Supplier end of the AES entropy req/ack interface. Buffers one wide
// generated-bits block and serves it word by word, least-significant first,
// with a zero-cycle acknowledge once the buffer holds data.
module aes_entropy_responder #(
    parameter int unsigned GenBitsWidth = 128,
    parameter int unsigned EntropyWidth = 32,
    parameter int unsigned NumWords     = GenBitsWidth / EntropyWidth,
    parameter int unsigned CntWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    genbits_valid_i,
    output logic                    genbits_ready_o,
    input  logic [GenBitsWidth-1:0] genbits_i,
    input  logic                    genbits_fips_i,
    input  logic                    entropy_req_i,
    output logic                    entropy_ack_o,
    output logic [EntropyWidth-1:0] entropy_o,
    output logic                    entropy_fips_o,
    output logic [CntWidth-1:0]     served_cnt_o
);

    localparam int unsigned IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;

    // The buffer valid bit is the state: EMPTY has no words, SERVING has at
    // least one unserved word.
    typedef enum logic {
        EMPTY   = 1'b0,
        SERVING = 1'b1
    } state_e;

    state_e                                 state_q, state_d;
    logic [IdxWidth-1:0]                    idx_q, idx_d;
    logic [NumWords-1:0][EntropyWidth-1:0]  buf_q, buf_d;
    logic                                   fips_q, fips_d;
    logic [CntWidth-1:0]                    cnt_q, cnt_d;

    logic buf_vld;
    logic last_word;
    logic ack;
    logic ready;
    logic load;

    assign buf_vld   = (state_q == SERVING);
    assign last_word = (idx_q == IdxWidth'(NumWords - 1));
    assign ack       = entropy_req_i & buf_vld & ~clr_i;
    // A refill is allowed in the very cycle the last word leaves, so a
    // continuously requesting consumer sees no bubble between blocks.
    assign ready     = ~clr_i & (~buf_vld | (ack & last_word));
    assign load      = genbits_valid_i & ready;

    assign genbits_ready_o = ready;
    assign entropy_ack_o   = ack;
    assign entropy_o       = ack ? buf_q[idx_q] : '0;
    assign entropy_fips_o  = ack & fips_q;
    assign served_cnt_o    = cnt_q;

    // Next-state: clear beats load, load beats consume.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        fips_d  = fips_q;
        if (clr_i) begin
            state_d = EMPTY;
            idx_d   = '0;
            buf_d   = '0;
            fips_d  = 1'b0;
        end else if (load) begin
            state_d = SERVING;
            idx_d   = '0;
            buf_d   = genbits_i;
            fips_d  = genbits_fips_i;
        end else if (ack) begin
            if (last_word) begin
                state_d = EMPTY;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Saturating served-word counter; only reset clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (ack && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State and buffer registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            buf_q   <= '0;
            fips_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            fips_q  <= fips_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_aes_entropy_responder.sv
// Directed bench for aes_entropy_responder with a word scoreboard.
module tb_aes_entropy_responder;

    localparam int unsigned GW = 128;
    localparam int unsigned EW = 32;
    localparam int unsigned NW = GW / EW;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          clr;
    logic          valid;
    logic          ready;
    logic [GW-1:0] genbits;
    logic          gfips;
    logic          req;
    logic          ack;
    logic [EW-1:0] entropy;
    logic          efips;
    logic [CW-1:0] cnt;

    logic          sat_ready;
    logic          sat_ack;
    logic [EW-1:0] sat_entropy;
    logic          sat_fips;
    logic [2:0]    sat_cnt;

    typedef struct packed {
        logic [EW-1:0] word;
        logic          fips;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    aes_entropy_responder #(
        .GenBitsWidth(GW),
        .EntropyWidth(EW),
        .CntWidth(CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .clr_i          (clr),
        .genbits_valid_i(valid),
        .genbits_ready_o(ready),
        .genbits_i      (genbits),
        .genbits_fips_i (gfips),
        .entropy_req_i  (req),
        .entropy_ack_o  (ack),
        .entropy_o      (entropy),
        .entropy_fips_o (efips),
        .served_cnt_o   (cnt)
    );

    // Narrow counter instance, fed the same stimulus, to reach saturation.
    aes_entropy_responder #(
        .GenBitsWidth(GW),
        .EntropyWidth(EW),
        .CntWidth(3)
    ) dut_sat (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .clr_i          (clr),
        .genbits_valid_i(valid),
        .genbits_ready_o(sat_ready),
        .genbits_i      (genbits),
        .genbits_fips_i (gfips),
        .entropy_req_i  (req),
        .entropy_ack_o  (sat_ack),
        .entropy_o      (sat_entropy),
        .entropy_fips_o (sat_fips),
        .served_cnt_o   (sat_cnt)
    );

    task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: pop on every ack, push the block's words on acceptance.
    always @(negedge clk) begin
        if (!rst_ni || clr) begin
            if (clr) chk("no_ack_in_clr", ack, 1'b0);
            q.delete();
        end else begin
            if (ack) begin
                chk("ack_needs_req", req, 1'b1);
                chk("sat_ack", sat_ack, 1'b1);
                chk("sb_nonempty", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word", entropy, e.word);
                    chk("fips", efips, e.fips);
                    chk("sat_word", sat_entropy, e.word);
                    chk("sat_fips", sat_fips, e.fips);
                end
            end
            if (valid && ready) begin
                for (int unsigned i = 0; i < NW; i++) begin
                    exp_t e;
                    e.word = genbits[i*EW +: EW];
                    e.fips = gfips;
                    q.push_back(e);
                end
            end
        end
    end

    initial begin
        logic [GW-1:0] b1, b2, b3, b4, b5, b6, b7;
        b1 = 128'h44444444_33333333_22222222_11111111;
        b2 = 128'h88888888_77777777_66666666_55555555;
        b3 = 128'hdeadbeef_cafef00d_0badc0de_12345678;
        b4 = 128'ha0a0a0a0_b1b1b1b1_c2c2c2c2_d3d3d3d3;
        b5 = 128'h0000000f_000000f0_00000f00_0000f000;
        b6 = 128'h13579bdf_2468ace0_fedcba98_76543210;
        b7 = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;

        rst_ni = 1'b0; clr = 1'b0; valid = 1'b0; genbits = '0; gfips = 1'b0; req = 1'b0;
        #2;
        chk("rst_ack", ack, 1'b0);
        chk("rst_entropy", entropy, '0);
        chk("rst_fips", efips, 1'b0);
        chk("rst_cnt", cnt, '0);
        chk("rst_ready", ready, 1'b1);
        nxt();
        rst_ni = 1'b1;
        nxt();

        // Block 1 with request held: four acks right after load.
        valid = 1'b1; genbits = b1; gfips = 1'b1; req = 1'b1;
        smp();
        chk("t1_ack_on_load", ack, 1'b0);
        chk("t1_ready_empty", ready, 1'b1);
        nxt();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t1_ack", ack, 1'b1);
            nxt();
        end
        smp();
        chk("t1_ack_after", ack, 1'b0);
        chk("t1_cnt", cnt, 16'd4);
        chk("t1_sat_cnt", sat_cnt, 3'd4);
        nxt();

        // Blocks 2 and 3: refill during the last word, 8 contiguous acks.
        valid = 1'b1; genbits = b2; gfips = 1'b0;
        smp();
        chk("t2_ready_empty", ready, 1'b1);
        nxt();
        valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                valid = 1'b1; genbits = b3; gfips = 1'b1;
            end
            smp();
            chk("t2_ack_contig", ack, 1'b1);
            if (i == 3) chk("t2_ready_last", ready, 1'b1);
            if (i == 2) chk("t2_ready_mid", ready, 1'b0);
            nxt();
            if (i == 3) valid = 1'b0;
        end
        smp();
        chk("t2_ack_after", ack, 1'b0);
        chk("t2_cnt", cnt, 16'd12);
        chk("t2_sat_cnt", sat_cnt, 3'd7);
        chk("t2_sb_empty", q.size(), 0);
        nxt();

        // Block 4: one-cycle requests separated by 3 idle cycles.
        req = 1'b0; valid = 1'b1; genbits = b4; gfips = 1'b0;
        nxt();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req = 1'b1;
            smp();
            chk("t3_ack_req", ack, 1'b1);
            nxt();
            req = 1'b0;
            for (int g = 0; g < 3; g++) begin
                smp();
                chk("t3_ack_gap", ack, 1'b0);
                nxt();
            end
        end
        chk("t3_cnt", cnt, 16'd16);
        chk("t3_sb_empty", q.size(), 0);

        // Block 5: two words, then clear with request and a pending block.
        valid = 1'b1; genbits = b5; gfips = 1'b1;
        nxt();
        valid = 1'b0; req = 1'b1;
        nxt();
        nxt();
        clr = 1'b1; valid = 1'b1; genbits = b6; gfips = 1'b0;
        smp();
        chk("t4_ack_clr", ack, 1'b0);
        chk("t4_ready_clr", ready, 1'b0);
        nxt();
        clr = 1'b0; valid = 1'b0;
        smp();
        chk("t4_ack_empty", ack, 1'b0);
        chk("t4_ready_after", ready, 1'b1);
        nxt();
        valid = 1'b1;
        nxt();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t4_ack_new", ack, 1'b1);
            nxt();
        end
        chk("t4_cnt", cnt, 16'd22);
        chk("t4_sb_empty", q.size(), 0);

        // Empty buffer with request held for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("t5_ack_idle", ack, 1'b0);
            chk("t5_ready_idle", ready, 1'b1);
            nxt();
        end
        valid = 1'b1; genbits = b7; gfips = 1'b1;
        smp();
        chk("t5_ack_load", ack, 1'b0);
        nxt();
        valid = 1'b0;
        smp();
        chk("t5_ack_next", ack, 1'b1);
        nxt();
        smp();
        chk("t5_ack_w1", ack, 1'b1);
        nxt();
        chk("t5_cnt", cnt, 16'd24);
        chk("t5_sat_hold", sat_cnt, 3'd7);

        // Asynchronous reset with idx = 2 and request still high.
        rst_ni = 1'b0;
        #1;
        chk("t6_ack", ack, 1'b0);
        chk("t6_entropy", entropy, '0);
        chk("t6_fips", efips, 1'b0);
        chk("t6_ready", ready, 1'b1);
        chk("t6_cnt", cnt, '0);
        chk("t6_sat_cnt", sat_cnt, 3'd0);
        nxt();
        rst_ni = 1'b1;
        smp();
        chk("t6_ack_after", ack, 1'b0);
        nxt();
        req = 1'b0;
        nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
